// File: rtl/sram_uart_transmit_interface_pkg.sv
// sram_uart_transmit_interface_pkg: FSM state encoding and the PPM header ROM
package sram_uart_transmit_interface_pkg;

  typedef enum logic [3:0] {
    S_ST_IDLE,
    S_ST_HEADER,
    S_ST_HEADER_WAIT,
    S_ST_READ_ADDR,
    S_ST_READ_WAIT1,
    S_ST_READ_WAIT2,
    S_ST_SEND_HIGH,
    S_ST_WAIT_HIGH,
    S_ST_SEND_LOW,
    S_ST_WAIT_LOW,
    S_ST_DONE
  } sram_uart_state_t;

  localparam int HEADER_LEN = 15;

  // "P6\n320 240\n255\n"
  localparam logic [7:0] HEADER_ROM [HEADER_LEN] = '{
    8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
    8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A
  };

endpackage

// File: rtl/sram_uart_transmit_interface_tx.sv
// uart_transmit_controller: 8N1 serializer with baud counter and Load/Empty handshake
module uart_transmit_controller #(
  parameter int BAUD_DIV = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clear,
  input  logic       i_load,
  input  logic [7:0] i_tx_data,
  output logic       o_empty,
  output logic       o_tx
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  logic        r_busy;
  logic        r_tx;
  logic [8:0]  r_data;
  logic [3:0]  r_bit;
  logic [15:0] r_baud;

  assign o_empty = !r_busy;
  assign o_tx    = r_tx;

  // bit 0 is the start bit, 1..8 data LSB first, 9 the stop bit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_tx   <= 1'b1;
      r_data <= '0;
      r_bit  <= '0;
      r_baud <= '0;
    end else if (i_clear) begin
      r_busy <= 1'b0;
      r_tx   <= 1'b1;
      r_data <= '0;
      r_bit  <= '0;
      r_baud <= '0;
    end else if (!r_busy) begin
      if (i_load) begin
        r_busy <= 1'b1;
        r_tx   <= 1'b0;
        r_data <= {1'b1, i_tx_data};
        r_bit  <= '0;
        r_baud <= '0;
      end
    end else if (r_baud == BAUD_LAST) begin
      r_baud <= '0;
      if (r_bit == 4'd9) begin
        r_busy <= 1'b0;
      end else begin
        r_tx   <= r_data[0];
        r_data <= r_data >> 1;
        r_bit  <= r_bit + 4'd1;
      end
    end else begin
      r_baud <= r_baud + 16'd1;
    end
  end

endmodule

// File: rtl/sram_uart_transmit_interface.sv
// sram_uart_transmit_interface: streams a PPM header and SRAM words out over UART
module sram_uart_transmit_interface
  import sram_uart_transmit_interface_pkg::*;
#(
  parameter int NUM_WORDS = 115200,
  parameter int BAUD_DIV  = 434,
  parameter int HEADER_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_initialize,
  input  logic        i_enable,
  input  logic [15:0] i_sram_read_data,
  output logic [17:0] o_sram_address,
  output logic        o_sram_we_n,
  output logic        o_uart_tx,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [18:0] LAST_WORD = 19'(NUM_WORDS - 1);
  localparam logic [3:0]  LAST_HDR  = 4'(HEADER_LEN - 1);

  sram_uart_state_t r_state;
  logic [18:0]      r_cnt;
  logic [17:0]      r_addr;
  logic [3:0]       r_hdr_idx;
  logic [15:0]      r_word;
  logic [7:0]       r_tx_data;
  logic             r_load;
  logic             r_seen;
  logic             w_empty;

  assign o_sram_address = r_addr;
  assign o_sram_we_n    = 1'b1;
  assign o_busy         = r_state != S_ST_IDLE && r_state != S_ST_DONE;
  assign o_done         = r_state == S_ST_DONE;

  uart_transmit_controller #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (i_initialize),
    .i_load   (r_load),
    .i_tx_data(r_tx_data),
    .o_empty  (w_empty),
    .o_tx     (o_uart_tx)
  );

  // Sequencer: header bytes, then read/high/low per word; r_seen tracks that
  // the loaded byte actually took Empty low before its Empty rise is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_hdr_idx <= '0;
      r_word    <= '0;
      r_tx_data <= '0;
      r_load    <= 1'b0;
      r_seen    <= 1'b0;
    end else if (i_initialize) begin
      r_state   <= S_ST_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_hdr_idx <= '0;
      r_word    <= '0;
      r_tx_data <= '0;
      r_load    <= 1'b0;
      r_seen    <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        S_ST_IDLE: if (i_enable) begin
          r_addr    <= '0;
          r_cnt     <= '0;
          r_hdr_idx <= '0;
          r_state   <= HEADER_EN != 0 ? S_ST_HEADER : S_ST_READ_ADDR;
        end
        S_ST_HEADER: if (w_empty) begin
          r_load    <= 1'b1;
          r_tx_data <= HEADER_ROM[r_hdr_idx];
          r_seen    <= 1'b0;
          r_state   <= S_ST_HEADER_WAIT;
        end
        S_ST_HEADER_WAIT: begin
          r_seen <= r_seen | !w_empty;
          if (r_seen && w_empty) begin
            r_hdr_idx <= r_hdr_idx + 4'd1;
            r_state   <= r_hdr_idx == LAST_HDR ? S_ST_READ_ADDR : S_ST_HEADER;
          end
        end
        S_ST_READ_ADDR:  r_state <= S_ST_READ_WAIT1;
        S_ST_READ_WAIT1: r_state <= S_ST_READ_WAIT2;
        S_ST_READ_WAIT2: begin
          r_word  <= i_sram_read_data;
          r_state <= S_ST_SEND_HIGH;
        end
        S_ST_SEND_HIGH: if (w_empty) begin
          r_load    <= 1'b1;
          r_tx_data <= r_word[15:8];
          r_seen    <= 1'b0;
          r_state   <= S_ST_WAIT_HIGH;
        end
        S_ST_WAIT_HIGH: begin
          r_seen <= r_seen | !w_empty;
          if (r_seen && w_empty) r_state <= S_ST_SEND_LOW;
        end
        S_ST_SEND_LOW: if (w_empty) begin
          r_load    <= 1'b1;
          r_tx_data <= r_word[7:0];
          r_seen    <= 1'b0;
          r_state   <= S_ST_WAIT_LOW;
        end
        S_ST_WAIT_LOW: begin
          r_seen <= r_seen | !w_empty;
          if (r_seen && w_empty) begin
            if (r_cnt == LAST_WORD) begin
              r_state <= S_ST_DONE;
            end else begin
              r_addr  <= r_addr + 18'd1;
              r_cnt   <= r_cnt + 19'd1;
              r_state <= S_ST_READ_ADDR;
            end
          end
        end
        S_ST_DONE: r_state <= S_ST_DONE;
        default:   r_state <= S_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_transmit_interface.sv
// tb_sram_uart_transmit_interface: directed checks of header, data order, timing, abort and completion
module tb_sram_uart_transmit_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_a = 1'b0, en_a = 1'b0, init_b = 1'b0, en_b = 1'b0;
  logic [15:0] rd_a, rd_b, s1_a, s1_b;
  logic [17:0] addr_a, addr_b;
  logic        we_a, we_b, tx_a, tx_b, busy_a, busy_b, done_a, done_b;
  int          errors = 0, checks = 0, we_bad = 0;

  localparam logic [15:0] MEM_A0 = 16'h1234, MEM_A1 = 16'hABCD, MEM_B0 = 16'h5AC3;

  always #5 clk = ~clk;

  sram_uart_transmit_interface #(.NUM_WORDS(2), .BAUD_DIV(4), .HEADER_EN(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_initialize(init_a), .i_enable(en_a),
    .i_sram_read_data(rd_a), .o_sram_address(addr_a), .o_sram_we_n(we_a),
    .o_uart_tx(tx_a), .o_busy(busy_a), .o_done(done_a));

  sram_uart_transmit_interface #(.NUM_WORDS(1), .BAUD_DIV(4), .HEADER_EN(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_initialize(init_b), .i_enable(en_b),
    .i_sram_read_data(rd_b), .o_sram_address(addr_b), .o_sram_we_n(we_b),
    .o_uart_tx(tx_b), .o_busy(busy_b), .o_done(done_b));

  // two-cycle SRAM read latency model
  always @(posedge clk) begin
    s1_a <= addr_a == 18'd0 ? MEM_A0 : MEM_A1;
    rd_a <= s1_a;
    s1_b <= addr_b == 18'd0 ? MEM_B0 : 16'hDEAD;
    rd_b <= s1_b;
  end

  always @(negedge clk) if (rst_n && (we_a !== 1'b1 || we_b !== 1'b1)) we_bad++;

  function automatic logic txv(input int sel);
    return sel != 0 ? tx_b : tx_a;
  endfunction

  // Samples one 40-cycle frame (BAUD_DIV=4) on the falling clock edge
  task automatic get_byte(input int sel, output logic [7:0] b, output bit fr_ok, output bit to);
    logic [39:0] s;
    int n;
    n = 0; to = 0; b = '0; fr_ok = 0;
    @(negedge clk);
    while (txv(sel) !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      to = 1;
      return;
    end
    for (int i = 0; i < 40; i++) begin
      s[i] = txv(sel);
      if (i < 39) @(negedge clk);
    end
    fr_ok = s[0] === 1'b0 && s[36] === 1'b1;
    for (int k = 0; k < 10; k++)
      for (int j = 1; j < 4; j++)
        if (s[4*k+j] !== s[4*k]) fr_ok = 0;
    for (int k = 0; k < 8; k++) b[k] = s[4*(k+1)];
  endtask

  task automatic pulse_enable_a();
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (addr_a !== 18'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", addr_a); end
    checks++; if (we_a !== 1'b1) begin errors++; $display("FAIL reset_we_n got=%b exp=1", we_a); end
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_a); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_header();
    logic [7:0] hdr [15] = '{8'h50, 8'h36, 8'h0A, 8'h33, 8'h32, 8'h30, 8'h20, 8'h32,
                             8'h34, 8'h30, 8'h0A, 8'h32, 8'h35, 8'h35, 8'h0A};
    logic [7:0] b;
    bit fr, to, fr_all;
    fr_all = 1;
    pulse_enable_a();
    for (int i = 0; i < 15; i++) begin
      get_byte(0, b, fr, to);
      fr_all &= fr;
      checks++;
      if (to || b !== hdr[i]) begin errors++; $display("FAIL header_byte%0d got=%h exp=%h timeout=%0b", i, b, hdr[i], to); end
    end
    checks++; if (!fr_all) begin errors++; $display("FAIL header_frame_timing got=bad exp=ok"); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL header_busy got=%b exp=1", busy_a); end
  endtask

  task automatic test_data_order();
    logic [7:0] exp [4] = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    logic [7:0] b;
    bit fr, to, fr_all;
    int n;
    fr_all = 1;
    for (int i = 0; i < 4; i++) begin
      get_byte(0, b, fr, to);
      fr_all &= fr;
      checks++;
      if (to || b !== exp[i]) begin errors++; $display("FAIL data_byte%0d got=%h exp=%h timeout=%0b", i, b, exp[i], to); end
    end
    checks++; if (!fr_all) begin errors++; $display("FAIL data_frame_timing got=bad exp=ok"); end
    n = 0;
    while (done_a !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL data_done got=%b exp=1", done_a); end
    checks++; if (addr_a !== 18'd1) begin errors++; $display("FAIL data_last_addr got=%h exp=1", addr_a); end
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL data_tx_idle got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL data_busy got=%b exp=0", busy_a); end
    checks++; if (we_bad != 0) begin errors++; $display("FAIL data_we_n got=%0d_low_samples exp=0", we_bad); end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    bit fr, to;
    int bad, n;
    bad = 0;
    @(negedge clk);
    init_a = 1'b1;
    @(negedge clk);
    init_a = 1'b0;
    pulse_enable_a();
    for (int i = 0; i < 16; i++) begin
      get_byte(0, b, fr, to);
      if (to) bad++;
    end
    checks++; if (bad != 0 || b !== 8'h12) begin errors++; $display("FAIL abort_prefix got=%h timeouts=%0d exp=12", b, bad); end
    n = 0;
    while (tx_a !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    init_a = 1'b1;
    @(negedge clk);
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL abort_tx got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy_a); end
    checks++; if (addr_a !== 18'd0) begin errors++; $display("FAIL abort_addr got=%h exp=0", addr_a); end
    init_a = 1'b0;
    pulse_enable_a();
    get_byte(0, b, fr, to);
    checks++; if (to || b !== 8'h50) begin errors++; $display("FAIL abort_restart got=%h exp=50 timeout=%0b", b, to); end
  endtask

  task automatic test_completion();
    logic [7:0] b0, b1;
    bit fr0, fr1, to0, to1;
    int n, bad;
    @(negedge clk);
    en_b = 1'b1;
    get_byte(1, b0, fr0, to0);
    get_byte(1, b1, fr1, to1);
    checks++; if (to0 || b0 !== 8'h5A) begin errors++; $display("FAIL complete_byte0 got=%h exp=5a", b0); end
    checks++; if (to1 || b1 !== 8'hC3) begin errors++; $display("FAIL complete_byte1 got=%h exp=c3", b1); end
    checks++; if (!(fr0 && fr1)) begin errors++; $display("FAIL complete_frame_timing got=bad exp=ok"); end
    n = 0;
    while (done_b !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (done_b !== 1'b1) begin errors++; $display("FAIL complete_done got=%b exp=1", done_b); end
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (tx_b !== 1'b1 || done_b !== 1'b1 || busy_b !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL complete_hold got=%0d_bad_cycles exp=0", bad); end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (tx_a !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++; if (tx_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL areset_precond tx=%b busy=%b exp tx=0 busy=1", tx_a, busy_a); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL areset_tx got=%b exp=1", tx_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", busy_a); end
    checks++; if (addr_a !== 18'd0 || we_a !== 1'b1) begin errors++; $display("FAIL areset_addr_we got=%h/%b exp=0/1", addr_a, we_a); end
    checks++; if (done_b !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", done_b); end
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_header();
    test_data_order();
    test_abort();
    test_completion();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
